prism_counter_sampler: RTL
==========================

Name: prism_counter_sampler

Overview:
Downstream consumer of the per-ID event counter bank. It drives the bank's monitor_id/monitor_reset interface and sweeps all IDs, either periodically or on a software trigger. Each ID is read and cleared atomically, and the result is emitted as a {id, count, last, seq} record on a valid/ready stream toward the statistics DMA/CSR readout. It snoops the bank's op_id/op_incr inputs so that an increment coinciding with a clear is never lost.

Parameters:
NIDS, 8, number of counter IDs (must match counter bank)
ID_WIDTH, $clog2(NIDS), ID width
MAX_VALUE, 65535, counter bank max value
VALUE_WIDTH, $clog2(MAX_VALUE+1), counter bank value width
PERIOD_WIDTH, 32, sweep period timer width
FIFO_DEPTH, 4, output record buffer depth (power of 2, >=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  periodic timer enable
period  in  PERIOD_WIDTH  sweep period in cycles; 0 = timer off
start  in  1  single-cycle software sweep trigger
skip_zero  in  1  suppress records with count 0 (except last ID)
monitor_id  out  ID_WIDTH  to counter bank
monitor_reset  out  1  to counter bank; clears monitor_id this cycle
monitor_count  in  VALUE_WIDTH  from counter bank (combinational on monitor_id)
snoop_op_id  in  ID_WIDTH  copy of the bank's op_id
snoop_op_incr  in  1  copy of the bank's op_incr
rec_valid  out  1  record valid
rec_ready  in  1  record accepted
rec_id  out  ID_WIDTH  counter ID
rec_count  out  VALUE_WIDTH+1  captured count, including coincident increment
rec_last  out  1  final record of the sweep
rec_seq  out  8  sweep sequence number
busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse at sweep end
overrun_count  out  16  triggers dropped while busy, saturating

Behaviour:
- Reset: FSM IDLE, FIFO flushed, timer=0, seq=0, overrun_count=0. All outputs 0; monitor_id=0.
- FSM IDLE:
  - trigger = start OR (enable AND period!=0 AND timer==period-1).
  - start and timer trigger in the same cycle produce one sweep.
  - On trigger: scan index:=0, go to SCAN.
- Timer:
  - Increments while enable and period!=0.
  - Resets to 0 on any trigger, or when enable=0.
  - Keeps counting during SCAN.
- FSM SCAN:
  - monitor_id = scan index.
  - Cycle "fires" when FIFO not full. On fire:
    - c = monitor_count + (snoop_op_incr AND snoop_op_id==index), computed in VALUE_WIDTH+1 bits with no wrap.
    - Write record {index, c, index==NIDS-1, seq}. Assert monitor_reset.
    - index++. After NIDS-1: go to DONE.
  - skip_zero=1, c==0, index!=NIDS-1: no write, no monitor_reset, index still advances.
  - FIFO full: no monitor_reset, index holds; counts keep accumulating in the bank.
  - Throughput: one ID per cycle when the sink is always ready.
- FSM DONE (1 cycle):
  - sweep_done=1, seq++ (255 wraps to 0), go to IDLE.
  - A trigger in this cycle is dropped and counted as an overrun.
- busy=1 in SCAN and DONE.
- Trigger while busy: dropped; overrun_count++, saturating at 0xFFFF.
- enable deasserted mid-sweep: sweep completes normally.
- Period or skip_zero changes mid-sweep take effect on the next cycle's evaluation.
- Output: records come from the FIFO head; rec_valid = FIFO non-empty. Earliest rec_valid is 1 cycle after the firing cycle.
  - Record fields stay stable while rec_valid=1 and rec_ready=0.
  - Push and pop in the same cycle are both allowed when not full. When full, no push occurs (no pass-through).
- reset asserted mid-sweep: everything aborts and is cleared, including buffered records. Bank contents are untouched by this block.

Decomposition:
- Package prism_counter_pkg holds: SEQ_WIDTH=8, OVERRUN_WIDTH=16, and enum sampler_state_t {IDLE, SCAN, DONE}.
- One sub-module, prism_sync_fifo (parameters WIDTH and DEPTH; push/full, pop/empty, synchronous active-high reset). It buffers the packed record.

Test Plan:
- NIDS=8, counts 0..7 = 5,0,3,0,0,0,0,9, start pulse, rec_ready=1, skip_zero=0 -> 8 records, ids 0..7 with the same counts, rec_last only on id 7, seq=0, sweep_done once, all counts 0 afterwards.
- Same counts, skip_zero=1 -> records (0,5), (2,3), (7,9,last); ids 1,3..6 never have monitor_reset asserted.
- Bank count[2]=4, snoop_op_incr on id 2 in the cycle id 2 is cleared -> rec_count=5; bank count[2]=0 afterwards.
- rec_ready=0 for 20 cycles during a sweep -> exactly 4 records buffered, monitor_reset stops and scan holds at id 4. Release -> remaining records arrive in order, none lost.
- period=50, enable=1, sink stalled so the sweep lasts >50 cycles -> overrun_count=1, next sweep seq=1. Two sweeps after seq=255 -> seq wraps to 0.
- reset pulse mid-sweep at id 3 -> rec_valid=0, busy=0, monitor_reset=0 next cycle. Next start begins again at id 0 with seq=0.

Source files
------------

// File: rtl/prism_counter_pkg.sv
// prism_counter_pkg
// Shared widths and the FSM state type for the counter sampler slice.
package prism_counter_pkg;

  // Sweep sequence number width (wraps 255 -> 0).
  localparam int SEQ_WIDTH     = 8;
  // Width of the saturating dropped-trigger counter.
  localparam int OVERRUN_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } sampler_state_t;

endpackage

// File: rtl/prism_sync_fifo.sv
// prism_sync_fifo
// Single-clock FIFO with first-word-fall-through output (pop_data shows the
// head while empty=0). Push is ignored when full, pop is ignored when empty.
// Push and pop in the same cycle are both honoured when not full.
// Ports:
//   clock, reset   : clock, synchronous active-high reset (flushes contents)
//   push/push_data : write request and data; full blocks the write
//   pop/pop_data   : read request and head data; empty blocks the read
module prism_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update and storage write; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/prism_counter_sampler.sv
// prism_counter_sampler
// Sweeps every ID of the per-ID event counter bank (periodically or on a
// software trigger), reading and clearing each counter atomically, and emits
// one {id, count, last, seq} record per ID on a valid/ready stream.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   enable, period         : periodic sweep timer (period 0 = timer off)
//   start                  : one-cycle software sweep trigger
//   skip_zero              : drop zero-count records except for the last ID
//   monitor_id/_reset      : read/clear interface to the counter bank
//   monitor_count          : bank value for monitor_id (combinational)
//   snoop_op_id/_incr      : copy of the bank's increment port
//   rec_*                  : output record stream (valid/ready)
//   busy, sweep_done       : sweep in progress / one-cycle end pulse
//   overrun_count          : triggers dropped while busy (saturating)
module prism_counter_sampler
  import prism_counter_pkg::*;
#(
  parameter int NIDS         = 8,
  parameter int ID_WIDTH     = $clog2(NIDS),
  parameter int MAX_VALUE    = 65535,
  parameter int VALUE_WIDTH  = $clog2(MAX_VALUE + 1),
  parameter int PERIOD_WIDTH = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [PERIOD_WIDTH-1:0]  period,
  input  logic                     start,
  input  logic                     skip_zero,
  output logic [ID_WIDTH-1:0]      monitor_id,
  output logic                     monitor_reset,
  input  logic [VALUE_WIDTH-1:0]   monitor_count,
  input  logic [ID_WIDTH-1:0]      snoop_op_id,
  input  logic                     snoop_op_incr,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [ID_WIDTH-1:0]      rec_id,
  output logic [VALUE_WIDTH:0]     rec_count,
  output logic                     rec_last,
  output logic [SEQ_WIDTH-1:0]     rec_seq,
  output logic                     busy,
  output logic                     sweep_done,
  output logic [OVERRUN_WIDTH-1:0] overrun_count
);

  localparam int REC_WIDTH = ID_WIDTH + VALUE_WIDTH + 1 + 1 + SEQ_WIDTH;
  localparam logic [ID_WIDTH-1:0]     LAST_ID    = ID_WIDTH'(NIDS - 1);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1'b1);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ZERO = {PERIOD_WIDTH{1'b0}};

  sampler_state_t           r_state;
  sampler_state_t           w_state_next;
  logic [ID_WIDTH-1:0]      r_index;
  logic [PERIOD_WIDTH-1:0]  r_timer;
  logic [SEQ_WIDTH-1:0]     r_seq;
  logic [OVERRUN_WIDTH-1:0] r_overrun;

  logic                     w_trigger;
  logic                     w_incr_hit;
  logic [VALUE_WIDTH:0]     w_count;
  logic                     w_is_last;
  logic                     w_skip;
  logic                     w_fire;
  logic                     w_push;
  logic                     w_busy;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [REC_WIDTH-1:0]     w_pop_data;

  assign w_trigger  = start ||
                      (enable && (period != PERIOD_ZERO) && (r_timer == period - PERIOD_ONE));
  // An increment landing on the ID being cleared is folded into this record,
  // since the bank's clear wins over its increment in that cycle.
  assign w_incr_hit = snoop_op_incr && (snoop_op_id == r_index);
  assign w_count    = {1'b0, monitor_count} + {{VALUE_WIDTH{1'b0}}, w_incr_hit};
  assign w_is_last  = (r_index == LAST_ID);
  assign w_skip     = skip_zero && (w_count == {(VALUE_WIDTH+1){1'b0}}) && !w_is_last;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = w_trigger ? SCAN : IDLE;
      SCAN:    w_state_next = (w_fire && w_is_last) ? DONE : SCAN;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: a scan cycle fires only when the buffer has room.
  always_comb begin
    w_fire     = 1'b0;
    w_push     = 1'b0;
    w_busy     = 1'b0;
    sweep_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
      end
      SCAN: begin
        w_busy = 1'b1;
        w_fire = !w_fifo_full;
        w_push = !w_fifo_full && !w_skip;
      end
      DONE: begin
        w_busy     = 1'b1;
        sweep_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign monitor_id    = r_index;
  assign monitor_reset = w_push;
  assign busy          = w_busy;
  assign overrun_count = r_overrun;

  // Scan index: restarts at 0 on a new sweep, advances on every fired cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_index <= {ID_WIDTH{1'b0}};
    end else if ((r_state == IDLE) && w_trigger) begin
      r_index <= {ID_WIDTH{1'b0}};
    end else if (w_fire) begin
      r_index <= w_is_last ? {ID_WIDTH{1'b0}} : r_index + ID_WIDTH'(1'b1);
    end else begin
      r_index <= r_index;
    end
  end

  // Period timer: cleared by any trigger or when disabled, free-runs during a sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= PERIOD_ZERO;
    end else if (!enable || w_trigger) begin
      r_timer <= PERIOD_ZERO;
    end else if (period != PERIOD_ZERO) begin
      r_timer <= r_timer + PERIOD_ONE;
    end else begin
      r_timer <= PERIOD_ZERO;
    end
  end

  // Sweep sequence number, bumped once per completed sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_seq <= {SEQ_WIDTH{1'b0}};
    end else if (r_state == DONE) begin
      r_seq <= r_seq + SEQ_WIDTH'(1'b1);
    end else begin
      r_seq <= r_seq;
    end
  end

  // Saturating count of triggers that arrive while a sweep is in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun <= {OVERRUN_WIDTH{1'b0}};
    end else if (w_busy && w_trigger && (r_overrun != {OVERRUN_WIDTH{1'b1}})) begin
      r_overrun <= r_overrun + OVERRUN_WIDTH'(1'b1);
    end else begin
      r_overrun <= r_overrun;
    end
  end

  prism_sync_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rec_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data ({r_index, w_count, w_is_last, r_seq}),
    .full      (w_fifo_full),
    .pop       (rec_ready),
    .pop_data  (w_pop_data),
    .empty     (w_fifo_empty)
  );

  assign rec_valid = !w_fifo_empty;
  assign {rec_id, rec_count, rec_last, rec_seq} = w_pop_data;

endmodule
